int_controller: RTL and testbench
=================================

INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameters: none; two interrupt sources, fixed.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 C_IRQ  output  [1:0]  request to CPU: bit1 = request valid, bit0 = index of the granted source (0 or 1).
REQ-005 C_IACK  input  1  CPU acknowledge of the request presented on C_IRQ.
REQ-006 C_IEND  input  1  CPU end-of-service for the acknowledged source.
REQ-007 IRQ  input  [0:1]  level-sensitive request lines from sources 0 and 1; bit 0 is the MSB position, so IRQ = 2'b10 means source 0 is requesting.
REQ-008 IACK  output  [0:1]  per-source acknowledge pulse; IACK[i] is for source i.
REQ-009 IEND  output  [0:1]  per-source end-of-service pulse; IEND[i] is for source i.
REQ-010 All outputs SHALL be registered.

Function
REQ-011 The controller SHALL implement a 3-state FSM: IDLE, REQUEST, SERVICE.
REQ-012 IDLE: when any IRQ bit is sampled 1, latch SRC and go to REQUEST.
- SRC = 0 if IRQ[0] = 1, else SRC = 1.
- Source 0 has fixed priority over source 1.
REQ-013 IDLE with IRQ = 00: stay in IDLE.
REQ-014 C_IRQ SHALL equal {1'b1, SRC} during every cycle in REQUEST, and 2'b00 in IDLE and SERVICE.
- C_IRQ is valid the cycle after the edge that sampled IRQ.
REQ-015 REQUEST: when C_IACK is sampled 1, go to SERVICE.
- IACK[SRC] = 1 for exactly one cycle, following that edge.
- C_IRQ returns to 00 in the same cycle.
REQ-016 REQUEST: SRC SHALL stay latched even if IRQ changes or drops; no re-arbitration until IDLE is re-entered.
REQ-017 SERVICE: when C_IEND is sampled 1, go to IDLE.
- IEND[SRC] = 1 for exactly one cycle, following that edge.
REQ-018 SERVICE: IRQ changes SHALL be ignored; pending requests are arbitrated only after IDLE is re-entered.
- The earliest new C_IRQ is therefore two cycles after the C_IEND edge.
REQ-019 Ignored inputs:
- C_IACK in IDLE or SERVICE.
- C_IEND in IDLE or REQUEST.
- A C_IACK held high for multiple cycles produces only one IACK pulse.
REQ-020 C_IACK and C_IEND both 1 in REQUEST: only C_IACK acts.
REQ-021 At most one bit of IACK and at most one bit of IEND SHALL be high in any cycle; IACK and IEND are never high in the same cycle.

Reset
REQ-022 RESET = 1 at a rising edge SHALL force:
- state IDLE, SRC = 0;
- C_IRQ = 00, IACK = 00, IEND = 00.
REQ-023 RESET SHALL take priority over all other inputs, including mid-handshake in REQUEST or SERVICE; no IACK or IEND pulse is generated for an aborted handshake.
REQ-024 After RESET is released, a held IRQ SHALL be arbitrated on the next edge.

Verification
REQ-025 Source 0 only:
- IRQ = 10 -> C_IRQ = 10.
- C_IACK 1 cycle -> IACK = 10 for one cycle, C_IRQ = 00.
- C_IEND 1 cycle -> IEND = 10 for one cycle, then idle.
REQ-026 Source 1 only:
- IRQ = 01 -> C_IRQ = 11.
- C_IACK -> IACK = 01 for one cycle.
- C_IEND -> IEND = 01 for one cycle.
REQ-027 Priority and pending:
- IRQ = 11 -> C_IRQ = 10.
- C_IACK, then IRQ = 01 -> IACK = 10.
- C_IEND -> IEND = 10, then C_IRQ = 11 without any new IRQ edge.
- Second C_IACK/C_IEND -> IACK = 01, then IEND = 01.
REQ-028 Out-of-order inputs:
- C_IEND in REQUEST -> no IEND pulse, C_IRQ unchanged.
- C_IACK in SERVICE -> no IACK pulse.
- C_IACK held 3 cycles -> single IACK pulse.
REQ-029 Reset mid-operation: RESET asserted in SERVICE -> all outputs 00 next cycle, no IEND pulse; with IRQ = 01 held after release -> C_IRQ = 11.
REQ-030 IRQ dropped in REQUEST: IRQ = 10 then IRQ = 00 -> C_IRQ stays 10 until C_IACK.

Source files
------------

// File: rtl/int_controller.sv
// Two-source interrupt controller.
// Arbitrates two level-sensitive request lines (source 0 has fixed priority),
// presents the winner to the CPU on C_IRQ, and relays the CPU's acknowledge
// and end-of-service handshake back to the owning source as one-cycle pulses.
// The granted source is held until service completes. Re-arbitration happens
// only once the controller is idle again.
module int_controller (
  input  logic       CLK,
  input  logic       RESET,
  output logic [1:0] C_IRQ,
  input  logic       C_IACK,
  input  logic       C_IEND,
  input  logic [0:1] IRQ,
  output logic [0:1] IACK,
  output logic [0:1] IEND
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state;
  logic   src;

  // One-hot per-source pulse vector for the given source index.
  // Source 0 sits in the left (MSB) position of the [0:1] vectors.
  function automatic logic [0:1] src_pulse(input logic s);
    logic [0:1] v;
    v    = 2'b00;
    v[s] = 1'b1;
    return v;
  endfunction

  // Fixed-priority pick: source 0 wins whenever it is requesting.
  function automatic logic pick_src(input logic [0:1] req);
    return req[0] ? 1'b0 : 1'b1;
  endfunction

  // Handshake FSM with registered outputs. The IACK/IEND pulses default low
  // every cycle so each one lasts exactly one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      src   <= 1'b0;
      C_IRQ <= 2'b00;
      IACK  <= 2'b00;
      IEND  <= 2'b00;
    end else begin
      IACK <= 2'b00;
      IEND <= 2'b00;
      case (state)
        IDLE: begin
          C_IRQ <= 2'b00;
          if (IRQ != 2'b00) begin
            src   <= pick_src(IRQ);
            C_IRQ <= {1'b1, pick_src(IRQ)};
            state <= REQUEST;
          end
        end
        REQUEST: begin
          // IRQ is not looked at here: the granted source stays latched even
          // if its line drops. C_IEND is meaningless before the acknowledge.
          C_IRQ <= {1'b1, src};
          if (C_IACK) begin
            C_IRQ <= 2'b00;
            IACK  <= src_pulse(src);
            state <= SERVICE;
          end
        end
        SERVICE: begin
          // A still-high C_IACK is ignored so a held acknowledge gives one
          // pulse only. New requests wait until IDLE.
          C_IRQ <= 2'b00;
          if (C_IEND) begin
            IEND  <= src_pulse(src);
            state <= IDLE;
          end
        end
        default: begin
          C_IRQ <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed handshakes with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the controller.
module tb_int_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] c_irq;
  logic       c_iack;
  logic       c_iend;
  logic [0:1] irq;
  logic [0:1] iack;
  logic [0:1] iend;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which source currently owns the CPU (-1 = none), and whether the
  // CPU has already acknowledged it.
  int         owner = -1;
  bit         acked = 1'b0;
  logic [1:0] exp_cirq = 2'b00;
  logic [0:1] exp_iack = 2'b00;
  logic [0:1] exp_iend = 2'b00;

  int_controller dut (
    .CLK    (clk),
    .RESET  (rst),
    .C_IRQ  (c_irq),
    .C_IACK (c_iack),
    .C_IEND (c_iend),
    .IRQ    (irq),
    .IACK   (iack),
    .IEND   (iend)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_step();
    exp_iack = 2'b00;
    exp_iend = 2'b00;
    if (rst) begin
      owner = -1;
      acked = 1'b0;
    end else if (owner < 0) begin
      if (irq != 2'b00) owner = irq[0] ? 0 : 1;
    end else if (!acked) begin
      if (c_iack) begin
        acked = 1'b1;
        exp_iack[owner] = 1'b1;
      end
    end else if (c_iend) begin
      exp_iend[owner] = 1'b1;
      owner = -1;
      acked = 1'b0;
    end
    if (owner >= 0 && !acked) exp_cirq = {1'b1, owner[0]};
    else                      exp_cirq = 2'b00;
  endtask

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge and compare all
  // outputs against it at the following falling edge.
  task automatic apply(input logic r, input logic [0:1] req, input logic a, input logic e);
    rst    = r;
    irq    = req;
    c_iack = a;
    c_iend = e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_c_irq", c_irq, exp_cirq);
    chk("model_iack",  iack,  exp_iack);
    chk("model_iend",  iend,  exp_iend);
  endtask

  initial begin
    rst = 1'b1; irq = 2'b00; c_iack = 1'b0; c_iend = 1'b0;

    // Reset state
    apply(1, 2'b00, 0, 0);
    apply(1, 2'b11, 1, 1);
    chk("reset_c_irq", c_irq, 2'b00);
    chk("reset_iack",  iack,  2'b00);
    chk("reset_iend",  iend,  2'b00);

    // Source 0 only
    apply(0, 2'b10, 0, 0); chk("s0_c_irq", c_irq, 2'b10);
    apply(0, 2'b10, 1, 0); chk("s0_iack", iack, 2'b10); chk("s0_c_irq_ack", c_irq, 2'b00);
    apply(0, 2'b00, 0, 0); chk("s0_iack_one_cycle", iack, 2'b00);
    apply(0, 2'b00, 0, 1); chk("s0_iend", iend, 2'b10);
    apply(0, 2'b00, 0, 0); chk("s0_iend_one_cycle", iend, 2'b00); chk("s0_idle", c_irq, 2'b00);

    // Source 1 only
    apply(0, 2'b01, 0, 0); chk("s1_c_irq", c_irq, 2'b11);
    apply(0, 2'b00, 1, 0); chk("s1_iack", iack, 2'b01);
    apply(0, 2'b00, 0, 1); chk("s1_iend", iend, 2'b01);
    apply(0, 2'b00, 0, 0);

    // Priority and pending
    apply(0, 2'b11, 0, 0); chk("prio_c_irq", c_irq, 2'b10);
    apply(0, 2'b01, 1, 0); chk("prio_iack", iack, 2'b10);
    apply(0, 2'b01, 0, 1); chk("prio_iend", iend, 2'b10); chk("prio_gap", c_irq, 2'b00);
    apply(0, 2'b01, 0, 0); chk("pend_c_irq", c_irq, 2'b11);
    apply(0, 2'b00, 1, 0); chk("pend_iack", iack, 2'b01);
    apply(0, 2'b00, 0, 1); chk("pend_iend", iend, 2'b01);

    // Out-of-order inputs, held acknowledge
    apply(0, 2'b10, 0, 0); chk("ooo_c_irq", c_irq, 2'b10);
    apply(0, 2'b00, 0, 1); chk("ooo_iend_in_req", iend, 2'b00); chk("ooo_c_irq_kept", c_irq, 2'b10);
    apply(0, 2'b00, 1, 0); chk("held_iack_1", iack, 2'b10);
    apply(0, 2'b00, 1, 0); chk("held_iack_2", iack, 2'b00);
    apply(0, 2'b00, 1, 0); chk("held_iack_3", iack, 2'b00);
    apply(0, 2'b00, 0, 1); chk("ooo_iend", iend, 2'b10);

    // C_IACK and C_IEND together in REQUEST
    apply(0, 2'b01, 0, 0); chk("both_c_irq", c_irq, 2'b11);
    apply(0, 2'b00, 1, 1); chk("both_iack", iack, 2'b01); chk("both_no_iend", iend, 2'b00);
    apply(0, 2'b00, 0, 1); chk("both_iend", iend, 2'b01);

    // Reset mid-service, held IRQ arbitrated right after release
    apply(0, 2'b01, 0, 0); chk("rst_mid_c_irq", c_irq, 2'b11);
    apply(0, 2'b01, 1, 0); chk("rst_mid_iack", iack, 2'b01);
    apply(1, 2'b01, 0, 1);
    chk("rst_mid_c_irq0", c_irq, 2'b00);
    chk("rst_mid_iack0", iack, 2'b00);
    chk("rst_mid_no_iend", iend, 2'b00);
    apply(0, 2'b01, 0, 0); chk("rst_release_c_irq", c_irq, 2'b11);
    apply(0, 2'b00, 1, 0);
    apply(0, 2'b00, 0, 1);

    // IRQ dropped while in REQUEST
    apply(0, 2'b10, 0, 0); chk("drop_c_irq_1", c_irq, 2'b10);
    apply(0, 2'b00, 0, 0); chk("drop_c_irq_2", c_irq, 2'b10);
    apply(0, 2'b00, 0, 0); chk("drop_c_irq_3", c_irq, 2'b10);
    apply(0, 2'b00, 1, 0); chk("drop_iack", iack, 2'b10);
    apply(0, 2'b00, 0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 59) == 0),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
